// File: rtl/gray_ctrl_pkg.sv
// Shared types and constants for the gray_ctrl block: FSM state encoding,
// active-low seven-segment patterns ({g,f,e,d,c,b,a}) and the digit encoder.
package gray_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STABLE  = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Decimal digit to active-low segment pattern; anything above 9 is blank.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/gray.sv
// 4-bit gray-to-binary converter (purely combinational).
// The MSB passes through; each lower binary bit is the XOR of the binary bit
// above it and the gray bit at the same position.
module gray (
  input  logic [3:0] gray_code,
  output logic [3:0] bin_code
);

  // Ripple the XOR chain down from the MSB.
  always_comb begin
    bin_code[3] = gray_code[3];
    bin_code[2] = bin_code[3] ^ gray_code[2];
    bin_code[1] = bin_code[2] ^ gray_code[1];
    bin_code[0] = bin_code[1] ^ gray_code[0];
  end

endmodule

// File: rtl/gray_ctrl.sv
// gray_ctrl: synchronizes a 4-bit gray-coded switch input, accepts a new code
// once it differs from the last accepted one, converts it to binary and shows
// the value (0..15) on a two-digit multiplexed seven-segment display.
//
// Build option: define GRAY_CTRL_DEBOUNCE_EN to require DEBOUNCE_CYCLES
// consecutive identical samples before a code is accepted. Without it, any
// change of the synchronized input is converted immediately and the STABLE
// state is never entered.
//
// Handshake: out_valid is a single-cycle strobe (no ready) asserted in the
// cycle bin_out first shows the newly converted value; conv_count has already
// advanced in that same cycle.
module gray_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REFRESH_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gray_in,
  output logic [3:0] bin_out,
  output logic       out_valid,
  output logic       busy,
  output logic [7:0] conv_count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [1:0] dbg_state
);

  // Parameter range guards, evaluated at elaboration.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("gray_ctrl: DEBOUNCE_CYCLES out of range 1..255");
  end
  if (REFRESH_CYCLES < 2 || REFRESH_CYCLES > 65535) begin : g_bad_refresh
    $error("gray_ctrl: REFRESH_CYCLES out of range 2..65535");
  end

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic [3:0]  sync_q1;
  logic [3:0]  sync;
  logic [3:0]  last_code;
  logic [3:0]  candidate;
  logic [3:0]  conv_bin;
  logic        cand_load;
  logic        conv_en;
  logic [15:0] refresh_cnt;
  logic        digit_sel;
  logic [3:0]  units;
  logic        tens_on;

`ifdef GRAY_CTRL_DEBOUNCE_EN
  localparam logic [7:0] DEB_TARGET = 8'(DEBOUNCE_CYCLES);
  logic [7:0] deb_cnt;
  logic       deb_load;
  logic       deb_inc;
`endif

  // Two-flop synchronizer for the asynchronous switch input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 4'd0;
      sync    <= 4'd0;
    end else begin
      sync_q1 <= gray_in;
      sync    <= sync_q1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_n   = state;
    cand_load = 1'b0;
    conv_en   = 1'b0;
`ifdef GRAY_CTRL_DEBOUNCE_EN
    deb_load  = 1'b0;
    deb_inc   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sync != last_code) begin
          cand_load = 1'b1;
`ifdef GRAY_CTRL_DEBOUNCE_EN
          deb_load  = 1'b1;
          state_n   = STABLE;
`else
          state_n   = CONVERT;
`endif
        end
      end
      STABLE: begin
`ifdef GRAY_CTRL_DEBOUNCE_EN
        // Returning to the accepted code cancels; a different code restarts
        // the count; a full run of matching samples triggers conversion.
        if (sync == last_code) begin
          state_n = IDLE;
        end else if (sync != candidate) begin
          cand_load = 1'b1;
          deb_load  = 1'b1;
        end else if (deb_cnt >= DEB_TARGET) begin
          state_n = CONVERT;
        end else begin
          deb_inc = 1'b1;
        end
`else
        state_n = IDLE;
`endif
      end
      CONVERT: begin
        conv_en = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Candidate capture, conversion result, accepted-code reference, counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      candidate  <= 4'd0;
      last_code  <= 4'd0;
      bin_out    <= 4'd0;
      conv_count <= 8'd0;
    end else begin
      if (cand_load) candidate <= sync;
      if (conv_en) begin
        bin_out    <= conv_bin;
        last_code  <= candidate;
        conv_count <= conv_count + 8'd1;
      end
    end
  end

`ifdef GRAY_CTRL_DEBOUNCE_EN
  // Debounce counter: loaded to 1 on a new candidate, bumped per match.
  always_ff @(posedge clk) begin
    if (rst)          deb_cnt <= 8'd0;
    else if (deb_load) deb_cnt <= 8'd1;
    else if (deb_inc)  deb_cnt <= deb_cnt + 8'd1;
  end
`endif

  gray u_gray (
    .gray_code (candidate),
    .bin_code  (conv_bin)
  );

  // Display refresh: flip the digit select every REFRESH_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= 16'd0;
      digit_sel   <= 1'b0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= 16'd0;
      digit_sel   <= ~digit_sel;
    end else begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  // Status outputs and the combinational digit/segment decode.
  always_comb begin
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
    dbg_state = state;
    tens_on   = (bin_out >= 4'd10);
    units     = tens_on ? (bin_out - 4'd10) : bin_out;
    an        = digit_sel ? 2'b01 : 2'b10;
    if (digit_sel) seg = tens_on ? SEG_1 : SEG_BLANK;
    else           seg = seg7_encode(units);
  end

endmodule

// File: tb/tb_gray_ctrl.sv
// Self-checking bench for gray_ctrl: reset values, a table of conversions
// with display checks, glitch/toggle/reset-abort sequences, and a random run
// long enough to wrap conv_count, all against a model built from the
// gray-code definition (b ^ (b >> 1) == g).
module tb_gray_ctrl;

  localparam int DEB = 4;
  localparam int REF = 8;
`ifdef GRAY_CTRL_DEBOUNCE_EN
  localparam int LAT     = 2 + DEB + 2;
  localparam int LAT_TOL = 1;
`else
  localparam int LAT     = 4;
  localparam int LAT_TOL = 0;
`endif

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic [3:0] bin_out;
  logic       out_valid;
  logic       busy;
  logic [7:0] conv_count;
  logic [6:0] seg;
  logic [1:0] an;
  logic [1:0] dbg_state;

  gray_ctrl #(.DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .bin_out    (bin_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .conv_count (conv_count),
    .seg        (seg),
    .an         (an),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;

  // Pulse monitor: counts every cycle out_valid is seen high.
  always @(negedge clk) if (out_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  // Model state.
  int         exp_count;
  logic [3:0] last_acc;
  int         conv_since_reset;

  typedef struct {
    logic [3:0] code;
    logic [3:0] bin;
    logic [6:0] units_seg;
    logic [6:0] tens_seg;
  } vec_t;
  vec_t vecs[8];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Binary value whose gray code is g, found by search over all 16 values.
  function automatic logic [3:0] model_bin(input logic [3:0] g);
    for (int b = 0; b < 16; b++)
      if (4'(b ^ (b >> 1)) == g) return 4'(b);
    return 4'd0;
  endfunction

  function automatic logic [6:0] model_units(input logic [3:0] v);
    logic [6:0] t[10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[int'(v) % 10];
  endfunction

  task automatic drive(input logic [3:0] g);
    @(negedge clk);
    gray_in = g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    gray_in = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    last_acc = 4'd0;
    conv_since_reset = 0;
  endtask

  // Counts rising edges from the current negedge until out_valid is seen.
  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid === 1'b1) ok = 1'b1;
    end
  endtask

  // Watches the display for 40 cycles: segment content per digit and the
  // length of every complete digit slot.
  task automatic check_display(input string tag, input logic [6:0] u, input logic [6:0] t);
    int bad = 0;
    int runs_bad = 0;
    int run = 0;
    int trans = 0;
    logic [1:0] prev_an;
    prev_an = an;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an === 2'b10)      begin if (seg !== u) bad++; end
      else if (an === 2'b01) begin if (seg !== t) bad++; end
      else bad++;
      if (an !== prev_an) begin
        trans++;
        if (trans > 1 && run != REF) runs_bad++;
        run = 1;
      end else run++;
      prev_an = an;
    end
    check_eq({"seg_", tag}, bad, 0);
    check_eq({"slot_len_", tag}, runs_bad, 0);
    check_range({"slot_toggles_", tag}, trans, 4, 6);
  endtask

  // Apply one new (different) code and check the resulting conversion.
  task automatic convert_one(input string tag, input logic [3:0] g, input logic [3:0] exp_bin);
    int lat;
    bit ok;
    drive(g);
    wait_valid(lat, ok);
    check_eq({"valid_seen_", tag}, ok, 1);
    check_range({"latency_", tag}, lat, LAT - LAT_TOL, LAT + LAT_TOL);
    exp_count = (exp_count + 1) & 255;
    last_acc = g;
    conv_since_reset++;
    check_eq({"bin_", tag}, bin_out, exp_bin);
    check_eq({"count_", tag}, conv_count, exp_count);
    @(negedge clk);
    check_eq({"valid_pulse_", tag}, out_valid, 0);
  endtask

  initial begin
    int base;
    int bad;
    vecs[0] = '{4'b0101, 4'b0110, S6, S_BLANK};
    vecs[1] = '{4'b1000, 4'b1111, S5, S1};
    vecs[2] = '{4'b0001, 4'b0001, S1, S_BLANK};
    vecs[3] = '{4'b1100, 4'b1000, S8, S_BLANK};
    vecs[4] = '{4'b0111, 4'b0101, S5, S_BLANK};
    vecs[5] = '{4'b1110, 4'b1011, S1, S1};
    vecs[6] = '{4'b1101, 4'b1001, S9, S_BLANK};
    vecs[7] = '{4'b1111, 4'b1010, S0, S1};

    rst = 1'b1;
    gray_in = 4'd0;
    do_reset();

    // Values held during reset.
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_an", an, 2'b10);
    check_eq("rst_seg", seg, S0);
    check_eq("rst_bin", bin_out, 0);
    check_eq("rst_count", conv_count, 0);
    rst = 1'b0;

    // Code 0 after reset: nothing to convert.
    base = valid_cnt;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (an === 2'b10 && seg !== S0) bad++;
      if (an === 2'b01 && seg !== S_BLANK) bad++;
      if (busy !== 1'b0) bad++;
    end
    check_eq("idle_pulses", valid_cnt - base, 0);
    check_eq("idle_bin", bin_out, 0);
    check_eq("idle_count", conv_count, 0);
    check_eq("idle_display", bad, 0);

    // Table of conversions with display content and slot timing.
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      check_eq({"table_model_", tag}, model_bin(vecs[i].code), vecs[i].bin);
      base = valid_cnt;
      convert_one(tag, vecs[i].code, vecs[i].bin);
      check_display(tag, vecs[i].units_seg, vecs[i].tens_seg);
      check_eq({"pulses_", tag}, valid_cnt - base, 1);
    end

    // One-cycle glitch away from the accepted code and back.
    base = valid_cnt;
    drive(4'b0110);
    drive(last_acc);
    repeat (30) @(negedge clk);
`ifdef GRAY_CTRL_DEBOUNCE_EN
    check_eq("glitch_pulses", valid_cnt - base, 0);
`else
    check_eq("glitch_pulses", valid_cnt - base, 2);
`endif
    exp_count = (exp_count + valid_cnt - base) & 255;
    conv_since_reset += valid_cnt - base;
    check_eq("glitch_bin", bin_out, model_bin(last_acc));
    check_eq("glitch_count", conv_count, exp_count);

    // Bouncing input 0011 <-> 0010 every 2 cycles, then settles on 0010.
    base = valid_cnt;
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 4'b0011 : 4'b0010);
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
`ifdef GRAY_CTRL_DEBOUNCE_EN
    check_eq("bounce_pulses", valid_cnt - base, 1);
`endif
    exp_count = (exp_count + valid_cnt - base) & 255;
    conv_since_reset += valid_cnt - base;
    last_acc = 4'b0010;
    check_eq("bounce_bin", bin_out, 4'b0011);
    check_eq("bounce_count", conv_count, exp_count);

    // Reset in the middle of acceptance aborts it silently.
    base = valid_cnt;
    drive(4'b1001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    gray_in = 4'd0;
    @(negedge clk);
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_bin", bin_out, 0);
    check_eq("abort_count", conv_count, 0);
    check_eq("abort_an", an, 2'b10);
    check_eq("abort_seg", seg, S0);
    rst = 1'b0;
    exp_count = 0;
    last_acc = 4'd0;
    conv_since_reset = 0;
    repeat (20) @(negedge clk);
    check_eq("abort_pulses", valid_cnt - base, 0);

    // Random codes until conv_count has wrapped.
    base = valid_cnt;
    for (int n = 0; n < 600 && conv_since_reset < 262; n++) begin
      logic [3:0] g;
      g = 4'($urandom_range(0, 15));
      if (g == last_acc) begin
        int b0;
        b0 = valid_cnt;
        drive(g);
        repeat (12) @(negedge clk);
        check_eq("rand_repeat_pulses", valid_cnt - b0, 0);
      end else begin
        convert_one($sformatf("r%0d", n), g, model_bin(g));
        if (exp_count == 0) check_eq("count_wrap", conv_count, 0);
        if ($urandom_range(0, 3) == 0) begin
          if (bin_out >= 4'd10) check_display($sformatf("r%0d", n), model_units(bin_out), S1);
          else                  check_display($sformatf("r%0d", n), model_units(bin_out), S_BLANK);
        end
      end
    end
    repeat (4) @(negedge clk);
    check_range("rand_conversions", conv_since_reset, 257, 1000);
    check_eq("rand_pulses_total", valid_cnt - base, conv_since_reset);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
